// File: rtl/down_ctr_pkg.sv
// down_ctr_pkg: shared types and constants for the down counter timer.
//   state_t       : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default counter width in bits
package down_ctr_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : down_ctr_pkg

// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if: control/status bundle of the down counter timer.
//   en       : count enable             (master -> slave)
//   load     : load strobe              (master -> slave)
//   load_val : start/reload value       (master -> slave)
//   periodic : reload mode, with load   (master -> slave)
//   q        : current count            (slave -> master)
//   tc       : terminal-count pulse     (slave -> master)
//   busy     : counting in progress     (slave -> master)
interface down_counter_timer_if
  import down_ctr_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             periodic;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  modport master (
    output en, load, load_val, periodic,
    input  q, tc, busy
  );

  modport slave (
    input  en, load, load_val, periodic,
    output q, tc, busy
  );

endinterface : down_counter_timer_if

// File: rtl/down_ctr_core.sv
// down_ctr_core: datapath of the down counter timer.
// Holds the count, the reload value and the reload mode; the controller
// tells it when to load, decrement or reload.
//   clk, rst    : clock, synchronous active-high reset
//   ld          : capture ld_val/ld_periodic, count <= ld_val
//   ld_val      : value captured on ld
//   ld_periodic : mode captured on ld
//   dec         : count <= count - 1
//   rld         : count <= captured reload value
//   q           : current count (registered)
//   periodic    : captured mode
//   q_is_one    : count == 1
//   q_is_zero   : count == 0
module down_ctr_core
  import down_ctr_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             ld_periodic,
  input  logic             dec,
  input  logic             rld,
  output logic [WIDTH-1:0] q,
  output logic             periodic,
  output logic             q_is_one,
  output logic             q_is_zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;

  // Next-state mux: load beats reload beats decrement; otherwise hold.
  always_comb begin
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    if (ld) begin
      cnt_d      = ld_val;
      reload_d   = ld_val;
      periodic_d = ld_periodic;
    end else if (rld) begin
      cnt_d = reload_q;
    end else if (dec) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= {WIDTH{1'b0}};
      reload_q   <= {WIDTH{1'b0}};
      periodic_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
    end
  end

  assign q         = cnt_q;
  assign periodic  = periodic_q;
  assign q_is_one  = (cnt_q == WIDTH'(1));
  assign q_is_zero = (cnt_q == {WIDTH{1'b0}});

endmodule : down_ctr_core

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter with a single-cycle
// terminal-count pulse and one-shot or periodic auto-reload.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of down_counter_timer_if (en, load, load_val,
//         periodic in; q, tc, busy out). All outputs are registered.
module down_counter_timer
  import down_ctr_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  down_counter_timer_if.slave  bus
);

  state_t           state_q, state_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             dec_s;
  logic             rld_s;
  logic [WIDTH-1:0] core_q_s;
  logic             periodic_s;
  logic             q_is_one_s;
  logic             q_is_zero_s;

  down_ctr_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .ld          (bus.load),
    .ld_val      (bus.load_val),
    .ld_periodic (bus.periodic),
    .dec         (dec_s),
    .rld         (rld_s),
    .q           (core_q_s),
    .periodic    (periodic_s),
    .q_is_one    (q_is_one_s),
    .q_is_zero   (q_is_zero_s)
  );

  // Controller next state: load restarts from any state, RUN counts on en,
  // IDLE/DONE wait for a load. tc defaults low so it is always one cycle.
  always_comb begin
    state_d = state_q;
    tc_d    = 1'b0;
    dec_s   = 1'b0;
    rld_s   = 1'b0;
    if (bus.load) begin
      // A zero load parks the counter without ever pulsing tc.
      state_d = (bus.load_val != {WIDTH{1'b0}}) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.en) begin
            if (q_is_zero_s) begin
              // Only reachable in periodic mode, the cycle after tc.
              rld_s   = periodic_s;
              state_d = periodic_s ? RUN : DONE;
            end else if (q_is_one_s) begin
              dec_s   = 1'b1;
              tc_d    = 1'b1;
              state_d = periodic_s ? RUN : DONE;
            end else begin
              dec_s = 1'b1;
            end
          end else begin
            state_d = RUN;
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
  end

  // Controller registers; tc and busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.q    = core_q_s;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer (WIDTH=4): each stimulus cycle
// queues the hand-computed q/tc/busy expected after its clock edge; an
// independent monitor pops and compares one entry per cycle.
module tb_down_counter_timer;

  typedef struct {
    int         id;
    logic [3:0] q;
    logic       tc;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   total;
  int   bad;
  int   vec;

  down_counter_timer_if #(.WIDTH(4)) bus ();

  down_counter_timer #(
    .WIDTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic step(input logic r, input logic l, input logic e, input logic p,
                      input logic [3:0] v, input logic [3:0] eq,
                      input logic etc, input logic eb);
    exp_t x;
    @(negedge clk);
    rst          = r;
    bus.load     = l;
    bus.en       = e;
    bus.periodic = p;
    bus.load_val = v;
    x.id   = vec;
    x.q    = eq;
    x.tc   = etc;
    x.busy = eb;
    sb.push_back(x);
    vec++;
    @(posedge clk);
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (bus.q !== e.q || bus.tc !== e.tc || bus.busy !== e.busy) begin
          bad++;
          $display("FAIL vec%0d: got q=%0d tc=%0b busy=%0b, want q=%0d tc=%0b busy=%0b",
                   e.id, bus.q, bus.tc, bus.busy, e.q, e.tc, e.busy);
        end
      end
    end
  end

  initial begin
    logic [3:0] os_q [5];
    logic [3:0] pr_q [7];
    logic       pr_tc [7];
    int         c;
    logic       e_s;
    logic       hit;

    os_q  = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    pr_q  = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
    pr_tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    total = 0;
    bad   = 0;
    vec   = 0;
    rst          = 1'b1;
    bus.load     = 1'b1;
    bus.en       = 1'b0;
    bus.periodic = 1'b0;
    bus.load_val = 4'd7;

    // Reset with a load pending: load is ignored.
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    // One-shot load 5.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, os_q[i], (i == 4), (i != 4));
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    end

    // Periodic load 3; the periodic input wiggles mid-run without effect.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, (i % 2 == 0), 4'd9, pr_q[i], pr_tc[i], 1'b1);
    end
    // Load on the q==0 edge wins over the reload.
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b1);

    // Enable gating: one-shot 15 with en toggling.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b1);
    c = 0;
    for (int i = 0; i < 32; i++) begin
      e_s = (i % 2 == 0);
      hit = e_s && (c < 15);
      if (hit) c++;
      step(1'b0, 1'b0, e_s, 1'b0, 4'd0, 4'(15 - c), hit && (c == 15), (c < 15));
    end

    // Collision: periodic 4, load 9 on the q==1 edge.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd4, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd8, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd7, 1'b0, 1'b1);

    // Mid-run reset at q=6, then a zero load.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 4'd8, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd6, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    end

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_down_counter_timer
